// File: rtl/hazard_pkg.sv
// Shared operand-forwarding encodings for the hazard/forwarding unit.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE   = 2'b00;
  localparam fwd_sel_t FWD_MEM_WB = 2'b01;
  localparam fwd_sel_t FWD_EX_MEM = 2'b10;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for in-flight long-latency writebacks.
module hazard_scoreboard #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned LAT_W  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   issue_i,
  input  logic [REG_AW-1:0]      issue_rd_i,
  input  logic [LAT_W-1:0]       issue_lat_i,
  output logic [2**REG_AW-1:0]   busy_o
);

  localparam int unsigned NumRegs = 2 ** REG_AW;

  logic [LAT_W-1:0] cnt_q [NumRegs];
  logic [LAT_W-1:0] cnt_d [NumRegs];
  logic             issue_valid;

  assign issue_valid = issue_i && (issue_rd_i != '0) && (issue_lat_i != '0);

  // A re-issue never shortens an entry, so an older longer write keeps the register busy.
  always_comb begin
    for (int unsigned r = 0; r < NumRegs; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      if (issue_valid && (issue_rd_i == REG_AW'(r)) && (issue_lat_i > cnt_d[r])) begin
        cnt_d[r] = issue_lat_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NumRegs; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_comb begin
    busy_o = '0;
    for (int unsigned r = 1; r < NumRegs; r++) begin
      busy_o[r] = (cnt_q[r] != '0);
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// EX operand forwarding, load-use / scoreboard stall generation and stall performance counters.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SRC       = 2,
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned LAT_W         = 4,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned STALL_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      id_ex_memread,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic                      mem_wb_regwrite,
  input  logic                      ll_issue,
  input  logic [REG_AW-1:0]         ll_rd,
  input  logic [LAT_W-1:0]          ll_lat,
  input  logic                      perf_clr,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic                      stall_err
);

  localparam int unsigned RunW = $clog2(STALL_TIMEOUT + 1);

  logic [2**REG_AW-1:0] busy;
  logic                 load_use;
  logic                 sb_hazard;
  logic [CNT_W-1:0]     stall_cycles_q, stall_cycles_d;
  logic [RunW-1:0]      run_q, run_d;
  logic                 err_q, err_d;

  hazard_scoreboard #(
    .REG_AW (REG_AW),
    .LAT_W  (LAT_W)
  ) u_scoreboard (
    .clk_i       (clk),
    .rst_i       (rst),
    .issue_i     (ll_issue),
    .issue_rd_i  (ll_rd),
    .issue_lat_i (ll_lat),
    .busy_o      (busy)
  );

  always_comb begin
    fwd_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      logic [REG_AW-1:0] rs;
      fwd_sel_t          sel;
      rs  = ex_rs[i*REG_AW +: REG_AW];
      sel = FWD_NONE;
      if (ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == rs)) begin
        sel = FWD_EX_MEM;
      end else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs)) begin
        sel = FWD_MEM_WB;
      end
      fwd_sel[i*2 +: 2] = sel;
    end
  end

  always_comb begin
    load_use  = 1'b0;
    sb_hazard = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      logic [REG_AW-1:0] rs;
      rs = id_rs[i*REG_AW +: REG_AW];
      if (id_rs_used[i]) begin
        if (id_ex_memread && (id_ex_rd != '0) && (rs == id_ex_rd)) begin
          load_use = 1'b1;
        end
        if (busy[rs]) begin
          sb_hazard = 1'b1;
        end
      end
    end
  end

  assign stall  = load_use | sb_hazard;
  assign bubble = stall;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (perf_clr) begin
      stall_cycles_d = '0;
    end else if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    // Run length holds at the timeout so it cannot wrap back below it.
    run_d = '0;
    err_d = err_q;
    if (stall) begin
      run_d = (run_q == RunW'(STALL_TIMEOUT)) ? run_q : run_q + RunW'(1);
      if (run_d == RunW'(STALL_TIMEOUT)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      run_q          <= '0;
      err_q          <= 1'b0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      run_q          <= run_d;
      err_q          <= err_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign stall_err    = err_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench: directed vector table, directed multi-cycle sequences, random vs. model.
module tb_hazard_fwd_unit;

  localparam int unsigned NUM_SRC = 2;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned LAT_W   = 4;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned TIMEOUT = 64;
  localparam int          CntMax  = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_SRC*REG_AW-1:0] ex_rs = '0;
  logic [NUM_SRC*REG_AW-1:0] id_rs = '0;
  logic [NUM_SRC-1:0]        id_rs_used = '0;
  logic [REG_AW-1:0]         id_ex_rd = '0;
  logic                      id_ex_memread = 1'b0;
  logic [REG_AW-1:0]         ex_mem_rd = '0;
  logic                      ex_mem_regwrite = 1'b0;
  logic [REG_AW-1:0]         mem_wb_rd = '0;
  logic                      mem_wb_regwrite = 1'b0;
  logic                      ll_issue = 1'b0;
  logic [REG_AW-1:0]         ll_rd = '0;
  logic [LAT_W-1:0]          ll_lat = '0;
  logic                      perf_clr = 1'b0;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall;
  logic                      bubble;
  logic [CNT_W-1:0]          stall_cycles;
  logic                      stall_err;

  hazard_fwd_unit #(
    .NUM_SRC       (NUM_SRC),
    .REG_AW        (REG_AW),
    .LAT_W         (LAT_W),
    .CNT_W         (CNT_W),
    .STALL_TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_rs           (ex_rs),
    .id_rs           (id_rs),
    .id_rs_used      (id_rs_used),
    .id_ex_rd        (id_ex_rd),
    .id_ex_memread   (id_ex_memread),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .ll_issue        (ll_issue),
    .ll_rd           (ll_rd),
    .ll_lat          (ll_lat),
    .perf_clr        (perf_clr),
    .fwd_sel         (fwd_sel),
    .stall           (stall),
    .bubble          (bubble),
    .stall_cycles    (stall_cycles),
    .stall_err       (stall_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: each register is busy through the last cycle index of any write still in flight.
  int cyc = 0;
  int busy_until [32];
  int m_cnt = 0;
  int m_run = 0;
  bit m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] m_fwd_port(input logic [REG_AW-1:0] rs);
    if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == rs) return 2'b10;
    if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    logic [REG_AW-1:0] rs;
    logic hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = id_rs[i*REG_AW +: REG_AW];
      if (id_rs_used[i]) begin
        if (id_ex_memread && id_ex_rd != 0 && rs == id_ex_rd) hit = 1'b1;
        if (rs != 0 && cyc <= busy_until[rs]) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) busy_until[r] = -1;
    m_cnt = 0;
    m_run = 0;
    m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".fwd"}, 32'(fwd_sel),
          32'({m_fwd_port(ex_rs[9:5]), m_fwd_port(ex_rs[4:0])}));
    check({tag, ".stall"}, 32'(stall), 32'(m_stall()));
    check({tag, ".bubble"}, 32'(bubble), 32'(m_stall()));
    check({tag, ".cnt"}, 32'(stall_cycles), 32'(m_cnt));
    check({tag, ".err"}, 32'(stall_err), 32'(m_err));
  endtask

  task automatic tick();
    bit s;
    s = m_stall();
    if (perf_clr) m_cnt = 0;
    else if (s && m_cnt < CntMax) m_cnt++;
    if (s) begin
      if (m_run < TIMEOUT) m_run++;
      if (m_run == TIMEOUT) m_err = 1'b1;
    end else begin
      m_run = 0;
    end
    if (ll_issue && ll_rd != 0 && ll_lat != 0 && busy_until[ll_rd] < cyc + int'(ll_lat))
      busy_until[ll_rd] = cyc + int'(ll_lat);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    #1;
  endtask

  task automatic idle_inputs();
    ex_rs = '0; id_rs = '0; id_rs_used = '0; id_ex_rd = '0; id_ex_memread = 1'b0;
    ex_mem_rd = '0; ex_mem_regwrite = 1'b0; mem_wb_rd = '0; mem_wb_regwrite = 1'b0;
    ll_issue = 1'b0; ll_rd = '0; ll_lat = '0; perf_clr = 1'b0;
  endtask

  typedef struct {
    logic [4:0] ex0, ex1, exm_rd;
    logic       exm_we;
    logic [4:0] mwb_rd;
    logic       mwb_we;
    logic [4:0] id0, id1;
    logic [1:0] used;
    logic [4:0] idex_rd;
    logic       idex_mr;
    logic [3:0] exp_fwd;
    logic       exp_stall;
  } vec_t;

  vec_t vecs [9];

  initial begin
    //          ex0 ex1 exm we mwb we id0 id1 used  idrd mr  fwd      stall
    vecs[0] = '{5,  5,  5,  1, 0,  0, 0,  0,  2'b00, 0,  0, 4'b1010, 1'b0};
    vecs[1] = '{5,  7,  5,  1, 7,  1, 0,  0,  2'b00, 0,  0, 4'b0110, 1'b0};
    vecs[2] = '{3,  0,  3,  1, 3,  1, 0,  0,  2'b00, 0,  0, 4'b0010, 1'b0};
    vecs[3] = '{0,  0,  0,  1, 0,  1, 0,  0,  2'b00, 0,  0, 4'b0000, 1'b0};
    vecs[4] = '{6,  2,  6,  0, 6,  1, 0,  0,  2'b00, 0,  0, 4'b0001, 1'b0};
    vecs[5] = '{0,  0,  0,  0, 0,  0, 0,  9,  2'b10, 9,  1, 4'b0000, 1'b1};
    vecs[6] = '{0,  0,  0,  0, 0,  0, 0,  9,  2'b01, 9,  1, 4'b0000, 1'b0};
    vecs[7] = '{0,  0,  0,  0, 0,  0, 0,  0,  2'b11, 0,  1, 4'b0000, 1'b0};
    vecs[8] = '{0,  0,  0,  0, 0,  0, 9,  0,  2'b01, 9,  0, 4'b0000, 1'b0};

    model_reset();
    idle_inputs();
    #2;
    check("rst_fwd", 32'(fwd_sel), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_cnt", 32'(stall_cycles), 0);
    check("rst_err", 32'(stall_err), 0);
    do_reset();
    check_all("post_rst");

    for (int v = 0; v < 9; v++) begin
      ex_rs = {vecs[v].ex1, vecs[v].ex0};
      ex_mem_rd = vecs[v].exm_rd; ex_mem_regwrite = vecs[v].exm_we;
      mem_wb_rd = vecs[v].mwb_rd; mem_wb_regwrite = vecs[v].mwb_we;
      id_rs = {vecs[v].id1, vecs[v].id0}; id_rs_used = vecs[v].used;
      id_ex_rd = vecs[v].idex_rd; id_ex_memread = vecs[v].idex_mr;
      #1;
      check($sformatf("vec%0d.fwd", v), 32'(fwd_sel), 32'(vecs[v].exp_fwd));
      check($sformatf("vec%0d.stall", v), 32'(stall), 32'(vecs[v].exp_stall));
      check($sformatf("vec%0d.bubble", v), 32'(bubble), 32'(vecs[v].exp_stall));
    end

    idle_inputs();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;

    // Scoreboard latency 4 on x12.
    id_rs = {5'd12, 5'd0}; id_rs_used = 2'b10;
    ll_issue = 1'b1; ll_rd = 12; ll_lat = 4;
    #1;
    check("sb4_pre", 32'(stall), 0);
    tick();
    ll_issue = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check_all("sb4");
      check($sformatf("sb4_c%0d", k), 32'(stall), 32'(k <= 4));
      tick();
    end
    check("sb4_cnt", 32'(stall_cycles), 4);

    // WAW: shorter re-issue must not release the register early.
    ll_issue = 1'b1; ll_rd = 12; ll_lat = 6;
    tick();
    ll_issue = 1'b0;
    check("waw_c1", 32'(stall), 1);
    tick();
    ll_issue = 1'b1; ll_lat = 2;
    check("waw_c2", 32'(stall), 1);
    tick();
    ll_issue = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      check_all("waw");
      check($sformatf("waw_c%0d", k), 32'(stall), 32'(k <= 6));
      tick();
    end

    // Issues to x0 or with zero latency are ignored.
    id_rs = {5'd7, 5'd0}; id_rs_used = 2'b11;
    ll_issue = 1'b1; ll_rd = 0; ll_lat = 5;
    tick();
    ll_rd = 7; ll_lat = 0;
    tick();
    ll_issue = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_all("ign");
      check($sformatf("ign_c%0d", k), 32'(stall), 0);
      tick();
    end

    // Reset mid-count flushes the scoreboard immediately.
    id_rs = {5'd12, 5'd0}; id_rs_used = 2'b10;
    ll_issue = 1'b1; ll_rd = 12; ll_lat = 10;
    tick();
    ll_issue = 1'b0;
    tick();
    check("rstmid_busy", 32'(stall), 1);
    rst = 1'b1;
    #1;
    check("rstmid_flush", 32'(stall), 0);
    check("rstmid_cnt", 32'(stall_cycles), 0);
    do_reset();
    check_all("rstmid_post");

    // Continuous stall: timeout, stickiness and counter saturation.
    id_rs = {5'd4, 5'd0}; id_rs_used = 2'b10;
    ll_issue = 1'b1; ll_rd = 4; ll_lat = 15;
    tick();
    for (int k = 1; k <= 70; k++) begin
      check_all("to");
      tick();
      if (k == 63) begin
        check("to_err_63", 32'(stall_err), 0);
        check("sat_63", 32'(stall_cycles), 32'(CntMax));
      end
      if (k == 64) check("to_err_64", 32'(stall_err), 1);
      if (k == 70) check("sat_70", 32'(stall_cycles), 32'(CntMax));
    end
    ll_issue = 1'b0; id_rs_used = 2'b00;
    for (int k = 0; k < 3; k++) tick();
    check("to_sticky", 32'(stall_err), 1);
    id_rs_used = 2'b10; perf_clr = 1'b1;
    #1;
    check("pclr_stall", 32'(stall), 1);
    tick();
    perf_clr = 1'b0;
    check("pclr_wins", 32'(stall_cycles), 0);
    do_reset();
    check("err_rst", 32'(stall_err), 0);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      ex_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used = 2'($urandom);
      id_ex_rd = 5'($urandom_range(0, 7)); id_ex_memread = ($urandom_range(0, 3) == 0);
      ex_mem_rd = 5'($urandom_range(0, 7)); ex_mem_regwrite = 1'($urandom);
      mem_wb_rd = 5'($urandom_range(0, 7)); mem_wb_regwrite = 1'($urandom);
      ll_issue = ($urandom_range(0, 3) == 0);
      ll_rd = 5'($urandom_range(0, 7)); ll_lat = 4'($urandom);
      perf_clr = ($urandom_range(0, 15) == 0);
      #1;
      check_all("rnd");
      tick();
    end
    check_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
